// File: rtl/seq_auction.sv
// Sequential sealed-bid auction engine: one bid per cycle, first/second-price
// pricing with a reserve, result offered on a valid/ready handshake.
module seq_auction #(
  parameter int unsigned NUM_BIDDERS = 8,
  parameter int unsigned W           = 3,
  parameter int unsigned IW          = (NUM_BIDDERS > 1) ? $clog2(NUM_BIDDERS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [W-1:0]  reserve,
  input  logic          bid_valid,
  input  logic [W-1:0]  bid_in,
  output logic          bid_ready,
  output logic          busy,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [IW-1:0] winner,
  output logic [W-1:0]  price,
  output logic          no_winner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic          mode_q;
  logic [W-1:0]  reserve_q;
  logic [W-1:0]  best;
  logic [W-1:0]  second;
  logic [IW-1:0] best_idx;
  logic [IW-1:0] cnt;
  logic          have_second;

  logic          accept;
  logic          last_bid;
  logic [W-1:0]  best_nx;
  logic [W-1:0]  second_nx;
  logic [IW-1:0] best_idx_nx;
  logic          have_second_nx;
  logic [IW-1:0] res_winner;
  logic [W-1:0]  res_price;
  logic          res_no_winner;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and bid acceptance
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bid   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = COLLECT;
      end
      COLLECT: begin
        accept   = bid_valid;
        last_bid = bid_valid && (cnt == IW'(NUM_BIDDERS - 1));
        if (last_bid) state_next = DONE;
      end
      DONE: begin
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Running top-two tracker including the bid accepted this cycle
  always_comb begin
    best_nx        = best;
    second_nx      = second;
    best_idx_nx    = best_idx;
    have_second_nx = have_second;
    if (accept) begin
      if ((bid_in > best) || (cnt == '0)) begin
        second_nx      = best;
        have_second_nx = (cnt != '0);
        best_nx        = bid_in;
        best_idx_nx    = cnt;
      end else if ((bid_in > second) || !have_second) begin
        second_nx      = bid_in;
        have_second_nx = 1'b1;
      end
    end
  end

  // Final result from the post-update trackers
  always_comb begin
    res_no_winner = (best_nx < reserve_q);
    res_winner    = best_idx_nx;
    if (!mode_q)            res_price = best_nx;
    else if (!have_second_nx) res_price = reserve_q;
    else if (second_nx > reserve_q) res_price = second_nx;
    else                    res_price = reserve_q;
    if (res_no_winner) begin
      res_winner = '0;
      res_price  = '0;
    end
  end

  // Auction datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 1'b0;
      reserve_q   <= '0;
      best        <= '0;
      second      <= '0;
      best_idx    <= '0;
      cnt         <= '0;
      have_second <= 1'b0;
      winner      <= '0;
      price       <= '0;
      no_winner   <= 1'b0;
    end else if ((state == IDLE) && start) begin
      mode_q      <= mode;
      reserve_q   <= reserve;
      best        <= '0;
      second      <= '0;
      best_idx    <= '0;
      cnt         <= '0;
      have_second <= 1'b0;
    end else if (accept) begin
      best        <= best_nx;
      second      <= second_nx;
      best_idx    <= best_idx_nx;
      have_second <= have_second_nx;
      cnt         <= cnt + IW'(1);
      if (last_bid) begin
        winner    <= res_winner;
        price     <= res_price;
        no_winner <= res_no_winner;
      end
    end
  end

  // Registered status flags decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      bid_ready    <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      bid_ready    <= (state_next == COLLECT);
      busy         <= (state_next != IDLE);
      result_valid <= (state_next == DONE);
    end
  end

endmodule
